serial_bus_master: RTL and testbench

Initiator end of the single-wire serial bus whose responders are the bus slave modules. It serialises a frame containing the slave ID, the address and, for writes, the data onto `data_bus_serial`. It collects the slave's acknowledgements and, for reads, the returned data. It presents a simple start/done handshake to the local requester. One instance sits between a processing element and the shared bus; bus arbitration is outside this block.

---
 rtl/serial_bus_master.sv | 175 +++++++++++++++++
 tb/tb_serial_bus_master.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_master.sv
// serial_bus_master: initiator of the single-wire serial bus. It serialises
// start/ID/address(/data) frames, then collects the acks and read data.
// Ports: start/rd_wrt_req/slave_id/addr_in/data_in request in; busy/done/error/data_out status out;
//        rd_wrt/bus_util bus control out; slave_busy observed; data_bus_serial bidirectional line.
module serial_bus_master #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     rd_wrt_req,
  input  logic [2:0]               slave_id,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_wrt,
  output logic                     bus_util,
  input  logic                     slave_busy,
  inout  wire                      data_bus_serial
);

  localparam int MAXW = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, START, SID, ADDR, ADDR_ACK, WR_PRE, WR_DATA,
    WR_ACK, RD_WAIT, RD_DATA, FINISH, ABORT
  } state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           bit_cnt;
  logic [TW-1:0]           tmo_cnt;
  logic                    ack_seen;
  logic                    wr_q;
  logic [2:0]              id_sh;
  logic [ADDRESS_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0]   data_sh;
  logic [DATA_WIDTH-1:0]   rx_sh;
  logic                    drv_en, drv_bit, ld_dout, line_in;
  logic                    serial_ph, wait_ph;
  logic                    unused_slave_busy;

  assign line_in         = data_bus_serial;
  assign data_bus_serial = drv_en ? drv_bit : 1'bz;

  // slave_busy is status only; completion is decided from line samples.
  assign unused_slave_busy = slave_busy;

  assign serial_ph = state inside {START, SID, ADDR, WR_PRE, WR_DATA, RD_DATA};
  assign wait_ph   = state inside {ADDR_ACK, WR_ACK, RD_WAIT};

  // busy/bus_util/rd_wrt drop in the FINISH/ABORT cycle, alongside the pulse.
  assign busy     = !(state inside {IDLE, FINISH, ABORT});
  assign bus_util = busy;
  assign rd_wrt   = busy & wr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    drv_en   = 1'b0;
    drv_bit  = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    ld_dout  = 1'b0;
    case (state)
      IDLE:     if (start) state_nx = START;
      START: begin
        drv_en  = 1'b1;
        drv_bit = 1'b0;
        if (bit_cnt == CW'(1)) state_nx = SID;
      end
      SID: begin
        drv_en  = 1'b1;
        drv_bit = id_sh[2];
        if (bit_cnt == CW'(2)) state_nx = ADDR;
      end
      ADDR: begin
        drv_en  = 1'b1;
        drv_bit = addr_sh[ADDRESS_WIDTH-1];
        if (bit_cnt == CW'(ADDRESS_WIDTH - 1)) state_nx = ADDR_ACK;
      end
      // The slave holds its ack low for two cycles: the cycle after the
      // first low sample is skipped so we never drive against it.
      ADDR_ACK: begin
        if (ack_seen)                                     state_nx = wr_q ? WR_PRE : RD_WAIT;
        else if (line_in && tmo_cnt == TW'(TIMEOUT - 1))  state_nx = ABORT;
      end
      WR_PRE: begin
        drv_en  = 1'b1;
        drv_bit = bit_cnt[0];  // 0 then 1
        if (bit_cnt == CW'(1)) state_nx = WR_DATA;
      end
      WR_DATA: begin
        drv_en  = 1'b1;
        drv_bit = data_sh[DATA_WIDTH-1];
        if (bit_cnt == CW'(DATA_WIDTH - 1)) state_nx = WR_ACK;
      end
      WR_ACK: begin
        if (!line_in)                            state_nx = FINISH;
        else if (tmo_cnt == TW'(TIMEOUT - 1))    state_nx = ABORT;
      end
      RD_WAIT: begin
        if (!line_in)                            state_nx = RD_DATA;
        else if (tmo_cnt == TW'(TIMEOUT - 1))    state_nx = ABORT;
      end
      // DATA_WIDTH sampling cycles, then one cycle to commit the byte so
      // data_out is already valid when done pulses.
      RD_DATA: begin
        if (bit_cnt == CW'(DATA_WIDTH)) begin
          ld_dout  = 1'b1;
          state_nx = FINISH;
        end
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      ABORT: begin
        error    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt  <= '0;
      tmo_cnt  <= '0;
      ack_seen <= 1'b0;
      wr_q     <= 1'b0;
      id_sh    <= '0;
      addr_sh  <= '0;
      data_sh  <= '0;
      rx_sh    <= '0;
      data_out <= '0;
    end else begin
      // Both counters restart on every state change.
      if (state_nx != state) bit_cnt <= '0;
      else if (serial_ph)    bit_cnt <= bit_cnt + 1'b1;

      if (state_nx != state) tmo_cnt <= '0;
      else if (wait_ph)      tmo_cnt <= tmo_cnt + 1'b1;

      // Only low samples taken while the line is released count as an ack.
      ack_seen <= (state == ADDR_ACK) && (state_nx == ADDR_ACK) && (ack_seen || !line_in);

      if (state == IDLE && start) begin
        wr_q    <= rd_wrt_req;
        id_sh   <= slave_id;
        addr_sh <= addr_in;
        data_sh <= data_in;
      end else begin
        if (state == SID)     id_sh   <= {id_sh[1:0], 1'b0};
        if (state == ADDR)    addr_sh <= {addr_sh[ADDRESS_WIDTH-2:0], 1'b0};
        if (state == WR_DATA) data_sh <= {data_sh[DATA_WIDTH-2:0], 1'b0};
      end

      if (state == RD_DATA && bit_cnt < CW'(DATA_WIDTH))
        rx_sh <= {rx_sh[DATA_WIDTH-2:0], line_in};
      if (ld_dout) data_out <= rx_sh;
    end
  end

endmodule

// File: tb/tb_serial_bus_master.sv
// Bench for serial_bus_master: acts as the bus slave with chosen response
// delays and checks every cycle of each frame against an expected timeline
// derived from the frame layout (bit positions and phase lengths).
module tb_serial_bus_master;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic          rd_wrt_req = 1'b0;
  logic          slave_busy = 1'b0;
  logic [2:0]    slave_id = '0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          busy, done, error, rd_wrt, bus_util;
  logic [DW-1:0] data_out;

  wire  sbus;
  pullup pu_sbus (sbus);
  logic tb_oe = 1'b0;
  logic tb_bit = 1'b1;
  assign sbus = tb_oe ? tb_bit : 1'bz;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_dout = '0;

  always #5 clk = ~clk;

  serial_bus_master #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .rd_wrt_req(rd_wrt_req),
    .slave_id(slave_id), .addr_in(addr_in), .data_in(data_in),
    .busy(busy), .done(done), .error(error), .data_out(data_out),
    .rd_wrt(rd_wrt), .bus_util(bus_util), .slave_busy(slave_busy),
    .data_bus_serial(sbus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Called at a negedge. Cycle c of a frame is the c-th clock period after
  // the edge that accepts start. a/w/r are slave response delays in cycles;
  // a delay >= TO means the slave never answers.
  task automatic run_txn(input logic wr, input logic [2:0] id, input logic [AW-1:0] addr,
                         input logic [DW-1:0] dat, input int a, input int w, input int r,
                         input bit poke_start);
    int   rel, p, wa, q, end_c;
    bit   ok;
    logic tb_v, tb_d, m_v, m_d, exp_line;
    rel = 6 + AW;  // first released cycle
    p = 0; wa = 0; q = 0; ok = 1'b1;
    if (a >= TO) begin
      end_c = rel + TO; ok = 1'b0;
    end else if (wr) begin
      p  = rel + a + 2;
      wa = p + 2 + DW;
      if (w >= TO) begin end_c = wa + TO; ok = 1'b0; end
      else end_c = wa + w + 1;
    end else begin
      q = rel + a + 2;
      if (r >= TO) begin end_c = q + TO; ok = 1'b0; end
      else end_c = q + r + DW + 2;
    end

    rd_wrt_req = wr; slave_id = id; addr_in = addr;
    data_in = wr ? dat : ~dat;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      start = poke_start && (c == 10);
      // slave side
      tb_v = 1'b0; tb_d = 1'b1;
      if (a < TO && (c == rel + a || c == rel + a + 1)) begin tb_v = 1'b1; tb_d = 1'b0; end
      if (a < TO && wr && w < TO && c == wa + w) begin tb_v = 1'b1; tb_d = 1'b0; end
      if (a < TO && !wr && r < TO) begin
        if (c == q + r) begin tb_v = 1'b1; tb_d = 1'b0; end
        else if (c > q + r && c <= q + r + DW) begin tb_v = 1'b1; tb_d = dat[DW-1-(c-q-r-1)]; end
      end
      tb_oe = tb_v; tb_bit = tb_d;
      // master side: expected frame bit for this cycle
      m_v = 1'b1; m_d = 1'b0;
      if (c <= 2)                                m_d = 1'b0;
      else if (c <= 5)                           m_d = id[5-c];
      else if (c <= 5 + AW)                      m_d = addr[AW+5-c];
      else if (wr && a < TO && c == p)           m_d = 1'b0;
      else if (wr && a < TO && c == p + 1)       m_d = 1'b1;
      else if (wr && a < TO && c >= p + 2 && c < p + 2 + DW) m_d = dat[DW-1-(c-p-2)];
      else m_v = 1'b0;
      exp_line = m_v ? m_d : (tb_v ? tb_d : 1'b1);
      if (c == end_c && ok && !wr) exp_dout = dat;
      #1;
      check($sformatf("line@%0d", c),     32'(sbus),     32'(exp_line));
      check($sformatf("busy@%0d", c),     32'(busy),     32'(c < end_c));
      check($sformatf("bus_util@%0d", c), 32'(bus_util), 32'(c < end_c));
      check($sformatf("rd_wrt@%0d", c),   32'(rd_wrt),   32'((c < end_c) && wr));
      check($sformatf("done@%0d", c),     32'(done),     32'(c == end_c && ok));
      check($sformatf("error@%0d", c),    32'(error),    32'(c == end_c && !ok));
      check($sformatf("data_out@%0d", c), 32'(data_out), 32'(exp_dout));
    end
    tb_oe = 1'b0;
    start = 1'b0;
    // one idle cycle between frames
    @(negedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done | error), 32'd0);
    check("idle_line", 32'(sbus), 32'd1);
  endtask

  initial begin
    logic          wr;
    logic [2:0]    id;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;

    #2 rstn = 1'b0;
    #1;
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_rd_wrt",   32'(rd_wrt),   32'd0);
    check("rst_bus_util", 32'(bus_util), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_line",     32'(sbus),     32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // directed cases
    run_txn(1'b1, 3'b011, 15'h1234, 8'hA5, 0, 0, 0, 1'b0);    // write, done at cycle 34
    run_txn(1'b0, 3'b101, 15'h0007, 8'h3C, 0, 0, 0, 1'b0);    // read, done at cycle 33
    run_txn(1'b1, 3'b110, 15'h0F0F, 8'h11, TO, 0, 0, 1'b0);   // no address ack
    run_txn(1'b0, 3'b110, 15'h7FFF, 8'h22, TO, 0, 0, 1'b0);   // no address ack, read
    run_txn(1'b1, 3'b001, 15'h4321, 8'h5A, 1, TO, 0, 1'b0);   // no write ack
    run_txn(1'b0, 3'b010, 15'h2222, 8'hC3, 0, 0, TO, 1'b0);   // no read start bit
    run_txn(1'b1, 3'b111, 15'h5555, 8'hFF, TO-1, TO-1, 0, 1'b0); // latest acks
    run_txn(1'b0, 3'b000, 15'h0000, 8'h81, TO-1, 0, TO-1, 1'b0);
    run_txn(1'b1, 3'b100, 15'h2AAA, 8'h96, 2, 1, 0, 1'b1);    // start poked during ADDR

    // reset while in WR_DATA; cycle 26 carries data bit 6 of A5 (a 0)
    rd_wrt_req = 1'b1; slave_id = 3'b011; addr_in = 15'h1234; data_in = 8'hA5;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      start = 1'b0;
      tb_oe = (c == 21 || c == 22);
      tb_bit = 1'b0;
    end
    #1;
    check("pre_rst_line", 32'(sbus), 32'd0);
    rstn = 1'b0;
    #1;
    check("mid_rst_line",     32'(sbus),     32'd1);
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_bus_util", 32'(bus_util), 32'd0);
    check("mid_rst_rd_wrt",   32'(rd_wrt),   32'd0);
    check("mid_rst_data_out", 32'(data_out), 32'd0);
    check("mid_rst_pulse",    32'(done | error), 32'd0);
    exp_dout = '0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("post_rst_pulse", 32'(done | error), 32'd0);
    check("post_rst_line",  32'(sbus), 32'd1);
    run_txn(1'b1, 3'b011, 15'h1234, 8'hA5, 0, 0, 0, 1'b0);

    // randomized frames
    for (int i = 0; i < 24; i++) begin
      wr   = 1'($urandom_range(0, 1));
      id   = 3'($urandom);
      addr = AW'($urandom);
      dat  = DW'($urandom);
      run_txn(wr, id, addr, dat, $urandom_range(0, TO), $urandom_range(0, TO),
              $urandom_range(0, TO), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
